// File: rtl/rvbridge_pkg.sv
// rtl/rvbridge_pkg.sv - shared register map, state encodings and bit positions for the CSR bridge
package rvbridge_pkg;

  // Per-channel capture state; encoding is what the status register reports
  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_IDLE    = 2'd1,
    ST_FRAME   = 2'd2,
    ST_DRAIN   = 2'd3
  } chan_state_e;

  // Register offsets within a channel's 8-word window
  localparam logic [2:0] REG_CTRL       = 3'd0;
  localparam logic [2:0] REG_STATUS     = 3'd1;
  localparam logic [2:0] REG_IRQ        = 3'd2;
  localparam logic [2:0] REG_WIDTH      = 3'd3;
  localparam logic [2:0] REG_HEIGHT     = 3'd4;
  localparam logic [2:0] REG_INTERLACED = 3'd5;
  localparam logic [2:0] REG_COUNT      = 3'd6;

  // Bit positions
  localparam int CTRL_GO_BIT    = 0;
  localparam int CTRL_IRQEN_BIT = 1;
  localparam int IRQ_EOF_BIT    = 0;
  localparam int IRQ_ERR_BIT    = 1;

  localparam int MAX_CHANNELS = 8;

endpackage

// File: rtl/rvbridge_csr_chan.sv
// rtl/rvbridge_csr_chan.sv - one monitored video channel: state machine, shadowed geometry, irq flags, frame counter
module rvbridge_csr_chan
  import rvbridge_pkg::*;
#(
  parameter logic [15:0] VIP_WIDTH      = 16'd720,
  parameter logic [15:0] VIP_HEIGHT     = 16'd576,
  parameter logic [3:0]  VIP_INTERLACED = 4'b0010,
  parameter int          CNT_WIDTH      = 16
) (
  input  logic        av_clk,
  input  logic        av_rst_n,
  input  logic        i_wr_en,
  input  logic [2:0]  i_reg_sel,
  input  logic [15:0] i_wr_data,
  input  logic        i_mon_valid,
  input  logic        i_mon_ready,
  input  logic        i_mon_sop,
  input  logic        i_mon_eop,
  output logic        o_go,
  output logic [15:0] o_width,
  output logic [15:0] o_height,
  output logic [3:0]  o_interlaced,
  output logic        o_irq,
  output logic [31:0] o_rd_data
);

  chan_state_e          r_state;
  logic                 r_ch_go;
  logic                 r_go_bit;
  logic                 r_irqen;
  logic                 r_eof;
  logic                 r_err;
  logic [CNT_WIDTH-1:0] r_count;
  logic [15:0]          r_pend_width;
  logic [15:0]          r_pend_height;
  logic [3:0]           r_pend_interlaced;
  logic [15:0]          r_act_width;
  logic [15:0]          r_act_height;
  logic [3:0]           r_act_interlaced;

  logic       w_beat;
  logic       w_sop_beat;
  logic       w_eop_beat;
  logic       w_wr_ctrl;
  logic       w_go_wr1;
  logic       w_go_wr0;
  logic [1:0] w_irq_clr;
  logic       w_wr_count;
  logic       w_err_ev;
  logic       w_load_ok;

  assign w_beat     = i_mon_valid & i_mon_ready;
  assign w_sop_beat = w_beat & i_mon_sop;
  assign w_eop_beat = w_beat & i_mon_eop;

  assign w_wr_ctrl  = i_wr_en && (i_reg_sel == REG_CTRL);
  assign w_go_wr1   = w_wr_ctrl &  i_wr_data[CTRL_GO_BIT];
  assign w_go_wr0   = w_wr_ctrl & ~i_wr_data[CTRL_GO_BIT];
  assign w_irq_clr  = (i_wr_en && (i_reg_sel == REG_IRQ)) ? i_wr_data[1:0] : 2'b00;
  assign w_wr_count = i_wr_en && (i_reg_sel == REG_COUNT);

  // A start mid-frame or an end outside a frame is a protocol error; a single-beat packet in IDLE is legal
  assign w_err_ev = (w_sop_beat && ((r_state == ST_FRAME) || (r_state == ST_DRAIN))) ||
                    (w_eop_beat && ((r_state == ST_STOPPED) ||
                                    ((r_state == ST_IDLE) && !w_sop_beat)));

  // Geometry may only change between frames, never on the cycle a frame starts
  assign w_load_ok = ((r_state == ST_STOPPED) || (r_state == ST_IDLE)) && !w_sop_beat;

  // Capture state machine with registered channel-enable output
  always_ff @(posedge av_clk or negedge av_rst_n) begin
    if (!av_rst_n) begin
      r_state <= ST_IDLE;
      r_ch_go <= 1'b1;
    end else begin
      case (r_state)
        ST_STOPPED: begin
          if (w_go_wr1) begin
            r_state <= ST_IDLE;
            r_ch_go <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (w_go_wr0) begin
            r_state <= ST_STOPPED;
            r_ch_go <= 1'b0;
          end else if (w_sop_beat && !w_eop_beat) begin
            r_state <= ST_FRAME;
          end
        end
        ST_FRAME: begin
          if (w_go_wr0) begin
            r_state <= w_eop_beat ? ST_STOPPED : ST_DRAIN;
            r_ch_go <= !w_eop_beat;
          end else if (w_eop_beat) begin
            r_state <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (w_go_wr1) begin
            r_state <= w_eop_beat ? ST_IDLE : ST_FRAME;
          end else if (w_eop_beat) begin
            r_state <= ST_STOPPED;
            r_ch_go <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_STOPPED;
          r_ch_go <= 1'b0;
        end
      endcase
    end
  end

  // Control bits, sticky irq flags (set wins over clear) and frame counter
  always_ff @(posedge av_clk or negedge av_rst_n) begin
    if (!av_rst_n) begin
      r_go_bit <= 1'b1;
      r_irqen  <= 1'b0;
      r_eof    <= 1'b0;
      r_err    <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_wr_ctrl) begin
        r_go_bit <= i_wr_data[CTRL_GO_BIT];
        r_irqen  <= i_wr_data[CTRL_IRQEN_BIT];
      end
      r_eof <= (r_eof & ~w_irq_clr[IRQ_EOF_BIT]) | w_eop_beat;
      r_err <= (r_err & ~w_irq_clr[IRQ_ERR_BIT]) | w_err_ev;
      if (w_wr_count) begin
        r_count <= w_eop_beat ? CNT_WIDTH'(1) : '0;
      end else if (w_eop_beat) begin
        r_count <= r_count + CNT_WIDTH'(1);
      end
    end
  end

  // Pending geometry takes host writes; active copy follows it only between frames
  always_ff @(posedge av_clk or negedge av_rst_n) begin
    if (!av_rst_n) begin
      r_pend_width      <= VIP_WIDTH;
      r_pend_height     <= VIP_HEIGHT;
      r_pend_interlaced <= VIP_INTERLACED;
      r_act_width       <= VIP_WIDTH;
      r_act_height      <= VIP_HEIGHT;
      r_act_interlaced  <= VIP_INTERLACED;
    end else begin
      if (w_load_ok) begin
        r_act_width      <= r_pend_width;
        r_act_height     <= r_pend_height;
        r_act_interlaced <= r_pend_interlaced;
      end
      if (i_wr_en && (i_reg_sel == REG_WIDTH))      r_pend_width      <= i_wr_data;
      if (i_wr_en && (i_reg_sel == REG_HEIGHT))     r_pend_height     <= i_wr_data;
      if (i_wr_en && (i_reg_sel == REG_INTERLACED)) r_pend_interlaced <= i_wr_data[3:0];
    end
  end

  // Register read mux; geometry reads return the pending values
  always_comb begin
    o_rd_data = '0;
    case (i_reg_sel)
      REG_CTRL:       o_rd_data[1:0]  = {r_irqen, r_go_bit};
      REG_STATUS:     o_rd_data[1:0]  = r_state;
      REG_IRQ:        o_rd_data[1:0]  = {r_err, r_eof};
      REG_WIDTH:      o_rd_data[15:0] = r_pend_width;
      REG_HEIGHT:     o_rd_data[15:0] = r_pend_height;
      REG_INTERLACED: o_rd_data[3:0]  = r_pend_interlaced;
      REG_COUNT:      o_rd_data       = 32'(r_count);
      default:        o_rd_data       = '0;
    endcase
  end

  assign o_go         = r_ch_go;
  assign o_width      = r_act_width;
  assign o_height     = r_act_height;
  assign o_interlaced = r_act_interlaced;
  assign o_irq        = r_irqen & (r_eof | r_err);

endmodule

// File: rtl/rvbridge_csr_mc.sv
// rtl/rvbridge_csr_mc.sv - multi-channel video monitor CSR block: address decode, channel array, read return
module rvbridge_csr_mc
  import rvbridge_pkg::*;
#(
  parameter int          CHANNELS       = 2,
  parameter logic [15:0] VIP_WIDTH      = 16'd720,
  parameter logic [15:0] VIP_HEIGHT     = 16'd576,
  parameter logic [3:0]  VIP_INTERLACED = 4'b0010,
  parameter int          CNT_WIDTH      = 16
) (
  input  logic                   av_clk,
  input  logic                   av_rst_n,
  input  logic [5:0]             av_address,
  input  logic                   av_read,
  input  logic                   av_write,
  input  logic [31:0]            av_writedata,
  output logic [31:0]            av_readdata,
  output logic                   av_readdatavalid,
  output logic                   av_waitrequest,
  output logic                   av_irq,
  input  logic [CHANNELS-1:0]    mon_valid,
  input  logic [CHANNELS-1:0]    mon_ready,
  input  logic [CHANNELS-1:0]    mon_sop,
  input  logic [CHANNELS-1:0]    mon_eop,
  output logic [CHANNELS-1:0]    ch_go,
  output logic [16*CHANNELS-1:0] ch_width,
  output logic [16*CHANNELS-1:0] ch_height,
  output logic [4*CHANNELS-1:0]  ch_interlaced
);

  logic [2:0]          w_ch_sel;
  logic [2:0]          w_reg_sel;
  logic [CHANNELS-1:0] w_wr_en;
  logic [CHANNELS-1:0] w_irq;
  logic [31:0]         w_rd_data [CHANNELS];
  logic [31:0]         w_rd_mux;
  logic                w_unused;
  logic [31:0]         r_readdata;
  logic                r_readdatavalid;

  assign w_ch_sel  = av_address[5:3];
  assign w_reg_sel = av_address[2:0];
  assign w_unused  = &{1'b0, av_writedata[31:16]};

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    assign w_wr_en[g] = av_write && (w_ch_sel == 3'(g));

    rvbridge_csr_chan #(
      .VIP_WIDTH      (VIP_WIDTH),
      .VIP_HEIGHT     (VIP_HEIGHT),
      .VIP_INTERLACED (VIP_INTERLACED),
      .CNT_WIDTH      (CNT_WIDTH)
    ) u_chan (
      .av_clk       (av_clk),
      .av_rst_n     (av_rst_n),
      .i_wr_en      (w_wr_en[g]),
      .i_reg_sel    (w_reg_sel),
      .i_wr_data    (av_writedata[15:0]),
      .i_mon_valid  (mon_valid[g]),
      .i_mon_ready  (mon_ready[g]),
      .i_mon_sop    (mon_sop[g]),
      .i_mon_eop    (mon_eop[g]),
      .o_go         (ch_go[g]),
      .o_width      (ch_width[16*g +: 16]),
      .o_height     (ch_height[16*g +: 16]),
      .o_interlaced (ch_interlaced[4*g +: 4]),
      .o_irq        (w_irq[g]),
      .o_rd_data    (w_rd_data[g])
    );
  end

  // Channel select for reads; unpopulated channel slots read as zero
  always_comb begin
    w_rd_mux = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_ch_sel == 3'(i)) w_rd_mux = w_rd_data[i];
    end
  end

  // Fixed one-cycle read return; data sampled before any same-cycle write lands
  always_ff @(posedge av_clk or negedge av_rst_n) begin
    if (!av_rst_n) begin
      r_readdata      <= '0;
      r_readdatavalid <= 1'b0;
    end else begin
      r_readdata      <= av_read ? w_rd_mux : 32'd0;
      r_readdatavalid <= av_read;
    end
  end

  assign av_readdata      = r_readdata;
  assign av_readdatavalid = r_readdatavalid;
  assign av_waitrequest   = 1'b0;
  assign av_irq           = |w_irq;

endmodule

// File: tb/tb_rvbridge_csr_mc.sv
// tb/tb_rvbridge_csr_mc.sv - scoreboard bench for rvbridge_csr_mc against a frame-level reference model
module tb_rvbridge_csr_mc;

  localparam int NCH = 2;

  logic            av_clk;
  logic            av_rst_n;
  logic [5:0]      av_address;
  logic            av_read;
  logic            av_write;
  logic [31:0]     av_writedata;
  logic [31:0]     av_readdata;
  logic            av_readdatavalid;
  logic            av_waitrequest;
  logic            av_irq;
  logic [NCH-1:0]  mon_valid, mon_ready, mon_sop, mon_eop;
  logic [NCH-1:0]  ch_go;
  logic [16*NCH-1:0] ch_width, ch_height;
  logic [4*NCH-1:0]  ch_interlaced;

  rvbridge_csr_mc #(.CHANNELS(NCH), .CNT_WIDTH(2)) dut (
    .av_clk(av_clk), .av_rst_n(av_rst_n), .av_address(av_address), .av_read(av_read),
    .av_write(av_write), .av_writedata(av_writedata), .av_readdata(av_readdata),
    .av_readdatavalid(av_readdatavalid), .av_waitrequest(av_waitrequest), .av_irq(av_irq),
    .mon_valid(mon_valid), .mon_ready(mon_ready), .mon_sop(mon_sop), .mon_eop(mon_eop),
    .ch_go(ch_go), .ch_width(ch_width), .ch_height(ch_height), .ch_interlaced(ch_interlaced)
  );

  initial av_clk = 1'b0;
  always #5 av_clk = ~av_clk;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  bit last_read;

  // Reference model: a channel is either inside a frame or not, plus the host's go request
  bit          m_run[NCH], m_req[NCH], m_inframe[NCH], m_irqen[NCH], m_eof[NCH], m_err[NCH];
  int          m_cnt[NCH];
  logic [15:0] m_pw[NCH], m_ph[NCH], m_aw[NCH], m_ah[NCH];
  logic [3:0]  m_pi[NCH], m_ai[NCH];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] m_status(int c);
    if (!m_inframe[c]) return m_run[c] ? 2'd1 : 2'd0;
    return m_req[c] ? 2'd2 : 2'd3;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_run[c] = 1; m_req[c] = 1; m_inframe[c] = 0;
      m_irqen[c] = 0; m_eof[c] = 0; m_err[c] = 0; m_cnt[c] = 0;
      m_pw[c] = 720; m_ph[c] = 576; m_pi[c] = 4'b0010;
      m_aw[c] = 720; m_ah[c] = 576; m_ai[c] = 4'b0010;
    end
  endtask

  function automatic logic [31:0] model_read(logic [5:0] addr);
    int c = int'(addr[5:3]);
    if (c >= NCH) return 32'd0;
    case (addr[2:0])
      3'd0: return {30'd0, m_irqen[c], m_req[c]};
      3'd1: return {30'd0, m_status(c)};
      3'd2: return {30'd0, m_err[c], m_eof[c]};
      3'd3: return {16'd0, m_pw[c]};
      3'd4: return {16'd0, m_ph[c]};
      3'd5: return {28'd0, m_pi[c]};
      3'd6: return 32'(m_cnt[c]);
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    for (int c = 0; c < NCH; c++) begin
      bit wr  = av_write && (int'(av_address[5:3]) == c);
      logic [2:0] rg = av_address[2:0];
      bit sop = mon_valid[c] && mon_ready[c] && mon_sop[c];
      bit eop = mon_valid[c] && mon_ready[c] && mon_eop[c];
      bit err_ev = (sop && m_inframe[c]) || (eop && !m_inframe[c] && !(sop && m_run[c]));
      if (!m_inframe[c] && !sop) begin
        m_aw[c] = m_pw[c]; m_ah[c] = m_ph[c]; m_ai[c] = m_pi[c];
      end
      m_eof[c] = (m_eof[c] && !(wr && rg == 3'd2 && av_writedata[0])) || eop;
      m_err[c] = (m_err[c] && !(wr && rg == 3'd2 && av_writedata[1])) || err_ev;
      if (wr && rg == 3'd6) m_cnt[c] = eop ? 1 : 0;
      else if (eop) m_cnt[c] = (m_cnt[c] + 1) % 4;
      if (wr && rg == 3'd3) m_pw[c] = av_writedata[15:0];
      if (wr && rg == 3'd4) m_ph[c] = av_writedata[15:0];
      if (wr && rg == 3'd5) m_pi[c] = av_writedata[3:0];
      if (wr && rg == 3'd0) begin
        m_irqen[c] = av_writedata[1];
        m_req[c]   = av_writedata[0];
        if (!m_inframe[c]) m_run[c] = av_writedata[0];
      end
      if (eop) begin
        m_inframe[c] = 0;
        m_run[c] = m_req[c];
      end else if (sop && m_run[c]) begin
        m_inframe[c] = 1;
      end
    end
  endtask

  task automatic check_outputs();
    bit irq = 0;
    for (int c = 0; c < NCH; c++) begin
      check($sformatf("ch_go[%0d]", c), 32'(ch_go[c]), 32'(m_run[c]));
      check($sformatf("ch_width[%0d]", c), 32'(ch_width[16*c +: 16]), 32'(m_aw[c]));
      check($sformatf("ch_height[%0d]", c), 32'(ch_height[16*c +: 16]), 32'(m_ah[c]));
      check($sformatf("ch_interlaced[%0d]", c), 32'(ch_interlaced[4*c +: 4]), 32'(m_ai[c]));
      irq |= m_irqen[c] && (m_eof[c] || m_err[c]);
    end
    check("av_irq", 32'(av_irq), 32'(irq));
    check("av_readdatavalid", 32'(av_readdatavalid), 32'(last_read));
    check("av_waitrequest", 32'(av_waitrequest), 32'd0);
  endtask

  task automatic tick();
    bit rd = av_read && av_rst_n;
    if (rd) exp_q.push_back(model_read(av_address));
    @(posedge av_clk);
    if (av_rst_n) model_step();
    last_read = rd;
    #1;
    check_outputs();
    av_read = 0; av_write = 0; av_address = '0; av_writedata = '0;
    mon_valid = '0; mon_ready = '0; mon_sop = '0; mon_eop = '0;
  endtask

  task automatic wr(int ch, int rg, logic [31:0] d);
    av_write = 1; av_address = {3'(ch), 3'(rg)}; av_writedata = d;
    tick();
  endtask

  task automatic rd(int ch, int rg);
    av_read = 1; av_address = {3'(ch), 3'(rg)};
    tick();
  endtask

  task automatic beat(int ch, bit s, bit e);
    mon_valid[ch] = 1; mon_ready[ch] = 1; mon_sop[ch] = s; mon_eop[ch] = e;
    tick();
  endtask

  task automatic do_reset();
    tick();
    av_rst_n = 0;
    model_reset();
    last_read = 0;
    tick();
    tick();
    av_rst_n = 1;
  endtask

  // Scoreboard monitor: every returned read is matched against the oldest expectation
  always @(negedge av_clk) begin
    if (av_rst_n && av_readdatavalid) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_readdata: got 0x%0h expected no read", av_readdata);
      end else begin
        check("readdata", av_readdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    av_rst_n = 0; av_read = 0; av_write = 0; av_address = '0; av_writedata = '0;
    mon_valid = '0; mon_ready = '0; mon_sop = '0; mon_eop = '0;
    last_read = 0;
    model_reset();
    tick(); tick();
    check("rst_readdata", av_readdata, 32'd0);
    check("rst_ch_go", 32'(ch_go), 32'b11);
    check("rst_width0", 32'(ch_width[15:0]), 32'd720);
    av_rst_n = 1;
    for (int r = 0; r < 8; r++) rd(0, r);
    for (int r = 0; r < 8; r++) rd(1, r);

    // Width write mid-frame is held until the frame ends
    beat(0, 1, 0);
    wr(0, 3, 1280);
    check("midframe_width", 32'(ch_width[15:0]), 32'd720);
    rd(0, 3);
    beat(0, 0, 0);
    check("midframe_width2", 32'(ch_width[15:0]), 32'd720);
    beat(0, 0, 1);
    tick();
    check("postframe_width", 32'(ch_width[15:0]), 32'd1280);

    // Stop request mid-frame drains until eop
    beat(1, 1, 0);
    wr(1, 0, 0);
    rd(1, 1);
    check("drain_go", 32'(ch_go[1]), 32'd1);
    beat(1, 0, 1);
    rd(1, 1);
    check("stopped_go", 32'(ch_go[1]), 32'd0);
    wr(1, 0, 1);
    rd(1, 1);

    // Interrupt with set-beats-clear
    wr(0, 0, 3);
    wr(0, 2, 3);
    beat(0, 1, 1);
    check("irq_on_eof", 32'(av_irq), 32'd1);
    av_write = 1; av_address = {3'd0, 3'd2}; av_writedata = 32'h1;
    mon_valid[0] = 1; mon_ready[0] = 1; mon_sop[0] = 1; mon_eop[0] = 1;
    tick();
    rd(0, 2);

    // Double start is an error and does not count a frame
    wr(0, 2, 3);
    rd(0, 6);
    beat(0, 1, 0);
    beat(0, 1, 0);
    rd(0, 2);
    rd(0, 6);
    beat(0, 0, 1);

    // Two-bit counter wrap and clear-with-eop
    wr(0, 6, 0);
    for (int i = 0; i < 4; i++) begin
      beat(0, 1, 1);
      rd(0, 6);
    end
    av_write = 1; av_address = {3'd0, 3'd6};
    mon_valid[0] = 1; mon_ready[0] = 1; mon_sop[0] = 1; mon_eop[0] = 1;
    tick();
    rd(0, 6);

    // Unpopulated channel, and read+write to the same register
    rd(7, 0);
    rd(7, 6);
    av_read = 1; av_write = 1; av_address = {3'd1, 3'd4}; av_writedata = 32'd480;
    tick();
    rd(1, 4);

    // Reset mid-frame lands in IDLE; a plain beat then leaves it there
    beat(0, 1, 0);
    do_reset();
    beat(0, 0, 0);
    rd(0, 1);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      int ch = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 7)) : int'($urandom_range(0, 1));
      av_address = {3'(ch), 3'($urandom_range(0, 7))};
      av_read  = ($urandom_range(0, 2) == 0);
      av_write = ($urandom_range(0, 3) == 0);
      av_writedata = $urandom;
      if (av_address[2:0] == 3'd0 && ($urandom_range(0, 3) != 0)) av_writedata[0] = 1'b1;
      for (int c = 0; c < NCH; c++) begin
        mon_valid[c] = $urandom_range(0, 1);
        mon_ready[c] = $urandom_range(0, 3) != 0;
        mon_sop[c]   = $urandom_range(0, 4) == 0;
        mon_eop[c]   = $urandom_range(0, 4) == 0;
        if (av_write && av_address[2:0] == 3'd0 && ch == c) mon_valid[c] = 1'b0;
      end
      tick();
    end

    tick(); tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rvbridge_csr_mc.md
RVBRIDGE_CSR_MC -- requirements
Module: rvbridge_csr_mc

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, number of monitored video channels (1..8).
REQ-002 SHALL have parameter VIP_WIDTH, default 16'd720, reset value of every channel width register.
REQ-003 SHALL have parameter VIP_HEIGHT, default 16'd576, reset value of every channel height register.
REQ-004 SHALL have parameter VIP_INTERLACED, default 4'b0010, reset value of every channel interlaced register.
REQ-005 SHALL have parameter CNT_WIDTH, default 16, frame counter width (1..32).
REQ-006 SHALL have port av_clk  in  1  clock for all logic.
REQ-007 SHALL have port av_rst_n  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have ports av_address in 6 ({channel[5:3], reg[2:0]}), av_read in 1, av_write in 1, av_writedata in 32.
REQ-009 SHALL have ports av_readdata out 32, av_readdatavalid out 1, av_waitrequest out 1 (tied 0), av_irq out 1.
REQ-010 SHALL have ports mon_valid, mon_ready, mon_sop, mon_eop, all in CHANNELS, per-channel Avalon-ST beat observation.
REQ-011 SHALL have ports ch_go out CHANNELS, ch_width out 16*CHANNELS, ch_height out 16*CHANNELS, ch_interlaced out 4*CHANNELS; channel n occupies slice n.

Function
REQ-012 A beat SHALL count only when mon_valid & mon_ready; sop_beat/eop_beat derived per channel accordingly.
REQ-013 Per-channel FSM SHALL have states STOPPED, IDLE, FRAME, DRAIN.
REQ-014 STOPPED->IDLE on go written 1; IDLE->FRAME on sop_beat; FRAME->IDLE on eop_beat; FRAME->DRAIN on go written 0; DRAIN->STOPPED on eop_beat; IDLE->STOPPED on go written 0; DRAIN->FRAME on go written 1.
REQ-015 sop_beat with eop_beat same cycle (single-beat packet) SHALL count as a complete frame; state unchanged from IDLE.
REQ-016 ch_go[n] SHALL be 1 in IDLE, FRAME, DRAIN; 0 in STOPPED.
REQ-017 Register map per channel: 0 ctrl {irqen,go}; 1 status {state[1:0]} (STOPPED=0, IDLE=1, FRAME=2, DRAIN=3); 2 irq {err,eof}; 3 width[15:0]; 4 height[15:0]; 5 interlaced[3:0]; 6 frame count; 7 reads 0.
REQ-018 Writes to regs 3..5 SHALL go to pending shadows; active ch_* outputs SHALL load pending values on any cycle the channel is STOPPED or IDLE with no sop_beat, never mid-frame.
REQ-019 Reads of regs 3..5 SHALL return pending values.
REQ-020 Read data SHALL appear with av_readdatavalid exactly 1 cycle after av_read; unused bits 0.
REQ-021 Channel index >= CHANNELS: reads SHALL return 0 (valid still asserted), writes ignored.
REQ-022 irq.eof SHALL set on eop_beat; irq.err SHALL set on sop_beat in FRAME/DRAIN or eop_beat in IDLE/STOPPED; writing 1 clears (W1C).
REQ-023 Set event and W1C clear in the same cycle SHALL leave the bit set.
REQ-024 av_irq SHALL be OR over channels of irqen & (eof | err).
REQ-025 Frame count SHALL increment on eop_beat, wrap 2^CNT_WIDTH-1 -> 0; any write to reg 6 clears; clear with simultaneous eop_beat yields 1.
REQ-026 Simultaneous av_read and av_write SHALL both execute; read returns pre-write value.

Reset
REQ-027 On av_rst_n low: FSM STOPPED... except go reset value 1 yields IDLE; irqen 0; irq bits 0; counts 0; active and pending registers = parameters; av_readdata 0; av_readdatavalid 0.
REQ-028 Reset mid-frame SHALL return to IDLE; the next beat without sop in IDLE SHALL not change state.

Structure
REQ-029 Register offsets, state encodings and bit positions SHALL live in shared package rvbridge_pkg.
REQ-030 One sub-module rvbridge_csr_chan SHALL implement a single channel (FSM, shadows, irq, counter), instantiated CHANNELS times by generate; top holds decode and read mux.

Verification
REQ-031 Write ch0 width 1280 during FRAME -> ch_width[15:0] stays 720 until eop_beat, reads 1280 immediately, outputs 1280 cycle after eop.
REQ-032 Write go=0 ch1 mid-frame -> status 3, ch_go[1]=1 until eop_beat, then status 0, ch_go[1]=0.
REQ-033 irqen=1, eop_beat ch0 -> av_irq=1; W1C write 0x1 same cycle as next eop -> bit remains 1.
REQ-034 sop_beat twice without eop -> irq.err=1; count unchanged.
REQ-035 CNT_WIDTH=2, 4 frames -> count 1,2,3,0; write reg 6 with eop -> 1.
REQ-036 Read address channel 7 with CHANNELS=2 -> av_readdata 0, av_readdatavalid 1 one cycle later.
